tx_resp_buffer: RTL and testbench

Response buffer between the system controller and the UART transmitter, in the REF_CLK domain. Accepts 16-bit ALU results and 8-bit register-read data, queues them as bytes in a small FIFO, and releases one byte at a time to the TX data synchronizer. The release uses a level handshake against the synchronized UART Busy flag. Lets the controller return to command decoding without stalling on the TX path.

---
 rtl/tx_resp_buffer_pkg.sv | 14 +
 rtl/tx_resp_buffer_fifo.sv | 68 ++++++
 rtl/tx_resp_buffer.sv | 137 +++++++++++++
 tb/tb_tx_resp_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_resp_buffer_pkg.sv
// Shared definitions for the TX response buffer: send FSM encoding and
// default FIFO geometry.
package tx_resp_buffer_pkg;

   localparam int DEFAULT_DEPTH      = 8;
   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE          = 2'd0,
      ST_REQ           = 2'd1,
      ST_WAIT_BUSY_LOW = 2'd2
   } tx_state_e;

endpackage

// File: rtl/tx_resp_buffer_fifo.sv
// Byte FIFO for the TX response buffer: up to three writes and one read per
// cycle, with registered Full/Empty derived from the post-edge count.
module tx_resp_fifo
   import tx_resp_buffer_pkg::*;
#(
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   localparam int AW        = $clog2(DEPTH),
   localparam int CW        = AW + 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [1:0]                 i_wr_num,
   input  logic [2:0][DATA_WIDTH-1:0] i_wr_data,
   input  logic                       i_rd_en,
   output logic [DATA_WIDTH-1:0]      o_rd_data,
   output logic [CW-1:0]              o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_full;
   logic                  r_empty;
   logic [CW-1:0]         w_count_nxt;

   // The caller only ever writes what fits, so the count cannot wrap.
   assign w_count_nxt = r_count + CW'(i_wr_num) - CW'(i_rd_en);

   // NOTE: storage is deliberately not reset; valid data is tracked by the
   // pointers and count, so clearing the array would only cost reset fan-out.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < 3; k++) begin
         if (k < int'(i_wr_num)) begin
            r_mem[r_wr_ptr + AW'(k)] <= i_wr_data[k];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(i_wr_num);
         if (i_rd_en) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign o_full    = r_full;
   assign o_empty   = r_empty;

endmodule

// File: rtl/tx_resp_buffer.sv
// Response buffer between the system controller and the UART TX path.
// Optional sticky drop flag enabled by defining TX_RESP_OVF_FLAG_EN.
module tx_resp_buffer
   import tx_resp_buffer_pkg::*;
#(
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   input  logic [DATA_WIDTH-1:0]   RdData,
   input  logic                    RdData_VLD,
   input  logic                    Busy,
   output logic [DATA_WIDTH-1:0]   TX_P_Data,
   output logic                    TX_D_VLD,
   output logic                    Full,
   output logic                    Empty,
   output logic                    Overflow,
   input  logic                    Ovf_Clr
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]                w_count;
   logic [CW-1:0]                w_free;
   logic [CW-1:0]                w_free_after_alu;
   logic                         w_alu_ok;
   logic                         w_rd_ok;
   logic                         w_drop;
   logic [1:0]                   w_wr_num;
   logic [2:0][DATA_WIDTH-1:0]   w_wr_data;
   logic [DATA_WIDTH-1:0]        w_head;
   logic                         w_empty;
   logic                         w_pop;
   tx_state_e                    r_state;
   tx_state_e                    w_state_nxt;
   logic [DATA_WIDTH-1:0]        r_tx_data;

   // Admission is whole-item; free space is taken before any same-cycle pop.
   assign w_free           = CW'(DEPTH) - w_count;
   assign w_alu_ok         = ALU_OUT_VLD && (w_free >= CW'(2));
   assign w_free_after_alu = w_alu_ok ? (w_free - CW'(2)) : w_free;
   assign w_rd_ok          = RdData_VLD && (w_free_after_alu != '0);
   assign w_drop           = (ALU_OUT_VLD && !w_alu_ok) || (RdData_VLD && !w_rd_ok);

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_wr_num  = 2'd0;
      w_wr_data = '0;
      if (w_alu_ok) begin
         w_wr_data[0] = ALU_OUT[DATA_WIDTH-1:0];
         w_wr_data[1] = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
         w_wr_data[2] = RdData;
         w_wr_num     = w_rd_ok ? 2'd3 : 2'd2;
      end else if (w_rd_ok) begin
         w_wr_data[0] = RdData;
         w_wr_num     = 2'd1;
      end
   end

   tx_resp_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .i_clk     (CLK),
      .i_rst_n   (RST),
      .i_wr_num  (w_wr_num),
      .i_wr_data (w_wr_data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_count   (w_count),
      .o_full    (Full),
      .o_empty   (w_empty)
   );

   assign Empty = w_empty;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:          if (!w_empty) w_state_nxt = ST_REQ;
         ST_REQ:           if (Busy)     w_state_nxt = ST_WAIT_BUSY_LOW;
         ST_WAIT_BUSY_LOW: if (!Busy)    w_state_nxt = ST_IDLE;
         default:                        w_state_nxt = ST_IDLE;
      endcase
   end

   // Busy already high on entry to REQ counts as acceptance of the byte.
   always_comb begin
      w_pop    = (r_state == ST_IDLE) && !w_empty;
      TX_D_VLD = (r_state == ST_REQ);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_tx_data <= '0;
      end else if (w_pop) begin
         r_tx_data <= w_head;
      end
   end

   assign TX_P_Data = r_tx_data;

`ifdef TX_RESP_OVF_FLAG_EN
   logic r_overflow;

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (Ovf_Clr) begin
         r_overflow <= 1'b0;
      end
   end

   assign Overflow = r_overflow;
`else
   logic w_ovf_unused;

   assign w_ovf_unused = Ovf_Clr ^ w_drop;
   assign Overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_tx_resp_buffer.sv
// Self-checking bench for tx_resp_buffer: directed pushes feed a scoreboard
// queue, a monitor checks each byte as TX_D_VLD rises, a Busy model answers.
module tb_tx_resp_buffer;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_OUT_VLD = 1'b0;
   logic [7:0]  RdData = '0;
   logic        RdData_VLD = 1'b0;
   logic        Busy;
   logic [7:0]  TX_P_Data;
   logic        TX_D_VLD;
   logic        Full;
   logic        Empty;
   logic        Overflow;
   logic        Ovf_Clr = 1'b0;

`ifdef TX_RESP_OVF_FLAG_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   int         n_pass  = 0;
   int         n_total = 0;
   logic [7:0] exp_q[$];
   bit         busy_en    = 1'b0;
   int         busy_delay = 0;
   int         busy_len   = 10;

   tx_resp_buffer dut (
      .CLK         (CLK),
      .RST         (RST),
      .ALU_OUT     (ALU_OUT),
      .ALU_OUT_VLD (ALU_OUT_VLD),
      .RdData      (RdData),
      .RdData_VLD  (RdData_VLD),
      .Busy        (Busy),
      .TX_P_Data   (TX_P_Data),
      .TX_D_VLD    (TX_D_VLD),
      .Full        (Full),
      .Empty       (Empty),
      .Overflow    (Overflow),
      .Ovf_Clr     (Ovf_Clr)
   );

   initial forever #5 CLK = ~CLK;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // UART model: accept a request after busy_delay cycles, stay busy busy_len cycles.
   initial begin
      Busy = 1'b0;
      forever begin
         @(negedge CLK);
         if (busy_en && TX_D_VLD && !Busy) begin
            repeat (busy_delay) @(negedge CLK);
            Busy = 1'b1;
            repeat (busy_len) @(negedge CLK);
            Busy = 1'b0;
         end
      end
   end

   // Monitor: each new request must carry the next scoreboard byte.
   initial begin
      logic prev_vld;
      logic [7:0] exp_b;
      prev_vld = 1'b0;
      forever begin
         @(negedge CLK);
         if (TX_D_VLD && !prev_vld) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_byte: got %h expected none", TX_P_Data);
            end else begin
               exp_b = exp_q.pop_front();
               check("tx_byte", {8'h00, TX_P_Data}, {8'h00, exp_b});
            end
         end
         prev_vld = TX_D_VLD;
      end
   end

   task automatic push(input logic av, input logic [15:0] a, input logic rv,
                       input logic [7:0] r, input bit a_exp, input bit r_exp);
      @(posedge CLK); #1;
      ALU_OUT_VLD = av;
      ALU_OUT     = a;
      RdData_VLD  = rv;
      RdData      = r;
      if (a_exp) begin
         exp_q.push_back(a[7:0]);
         exp_q.push_back(a[15:8]);
      end
      if (r_exp) exp_q.push_back(r);
      @(posedge CLK); #1;
      ALU_OUT_VLD = 1'b0;
      RdData_VLD  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int i;
      for (i = 0; i < 2000; i++) begin
         @(negedge CLK);
         if (exp_q.size() == 0 && Empty && !TX_D_VLD && !Busy) break;
      end
      check({name, "_drain_in_time"}, 16'(i < 2000), 16'd1);
      check({name, "_empty_after"}, Empty, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int i;
      logic found;

      // Reset values
      repeat (3) @(posedge CLK);
      #1;
      check("rst_vld",   TX_D_VLD,  1'b0);
      check("rst_data",  TX_P_Data, 8'h00);
      check("rst_empty", Empty,     1'b1);
      check("rst_full",  Full,      1'b0);
      check("rst_ovf",   Overflow,  1'b0);
      @(negedge CLK);
      RST = 1'b1;

      // ALU result, latency 2 edges, bytes low then high
      busy_en  = 1'b1;
      busy_len = 10;
      push(1'b1, 16'hA55A, 1'b0, 8'h00, 1'b1, 1'b0);
      check("lat_edge1_vld", TX_D_VLD, 1'b0);
      @(posedge CLK); #1;
      check("lat_edge2_vld",  TX_D_VLD,  1'b1);
      check("lat_edge2_data", TX_P_Data, 8'h5A);
      wait_drain("alu");

      // Same-cycle ALU + RdData: 34, 12, 77
      push(1'b1, 16'h1234, 1'b1, 8'h77, 1'b1, 1'b1);
      wait_drain("both");

      // Fill to DEPTH-1 with UART stalled (first byte sits in REQ)
      busy_en = 1'b0;
      for (int k = 0; k < 8; k++) push(1'b0, 16'h0000, 1'b1, 8'(8'h10 + k), 1'b0, 1'b1);
      check("fill7_full",  Full,  1'b0);
      check("fill7_empty", Empty, 1'b0);
      push(1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b0, 1'b0);
      check("alu_drop_full",  Full,     1'b0);
      check("alu_drop_empty", Empty,    1'b0);
      check("alu_drop_ovf",   Overflow, OVF_EN);
      @(posedge CLK); #1;
      check("ovf_sticky", Overflow, OVF_EN);
      Ovf_Clr = 1'b1;
      @(posedge CLK); #1;
      Ovf_Clr = 1'b0;
      check("ovf_cleared", Overflow, 1'b0);
      push(1'b1, 16'hBEEF, 1'b1, 8'h99, 1'b0, 1'b1);
      check("rd_after_alu_reject_full", Full,     1'b1);
      check("rd_after_alu_reject_ovf",  Overflow, OVF_EN);
      @(posedge CLK); #1;
      Ovf_Clr     = 1'b1;
      ALU_OUT_VLD = 1'b1;
      ALU_OUT     = 16'hDEAD;
      @(posedge CLK); #1;
      Ovf_Clr     = 1'b0;
      ALU_OUT_VLD = 1'b0;
      check("set_wins_ovf",  Overflow, OVF_EN);
      check("set_wins_full", Full,     1'b1);
      Ovf_Clr = 1'b1;
      @(posedge CLK); #1;
      Ovf_Clr = 1'b0;
      check("ovf_cleared2", Overflow, 1'b0);
      busy_en = 1'b1;
      wait_drain("fill");

      // Busy held low 20 cycles in REQ
      busy_delay = 20;
      push(1'b0, 16'h0000, 1'b1, 8'h3C, 1'b0, 1'b1);
      found = 1'b0;
      for (i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (TX_D_VLD) begin
            found = 1'b1;
            break;
         end
      end
      check("hold_req_seen", found, 1'b1);
      for (int k = 0; k < 19; k++) begin
         @(negedge CLK);
         check("hold_vld",  TX_D_VLD,  1'b1);
         check("hold_data", TX_P_Data, 8'h3C);
      end
      found = 1'b0;
      for (i = 0; i < 30; i++) begin
         @(posedge CLK);
         if (Busy) begin
            found = 1'b1;
            break;
         end
      end
      #1;
      check("hold_busy_seen",   found,    1'b1);
      check("vld_drop_on_busy", TX_D_VLD, 1'b0);
      busy_delay = 0;
      wait_drain("hold");

      // Reset while in REQ with 3 bytes queued
      busy_en = 1'b0;
      push(1'b1, 16'hC0DE, 1'b1, 8'h42, 1'b1, 1'b1);
      push(1'b0, 16'h0000, 1'b1, 8'h55, 1'b0, 1'b1);
      @(posedge CLK); #1;
      check("pre_rst_vld",   TX_D_VLD,  1'b1);
      check("pre_rst_data",  TX_P_Data, 8'hDE);
      check("pre_rst_empty", Empty,     1'b0);
      @(negedge CLK); #2;
      RST = 1'b0;
      #1;
      check("async_rst_vld",   TX_D_VLD,  1'b0);
      check("async_rst_data",  TX_P_Data, 8'h00);
      check("async_rst_empty", Empty,     1'b1);
      check("async_rst_full",  Full,      1'b0);
      check("async_rst_ovf",   Overflow,  1'b0);
      exp_q.delete();
      @(negedge CLK);
      RST     = 1'b1;
      busy_en = 1'b1;
      repeat (20) @(negedge CLK);
      check("post_rst_vld",   TX_D_VLD, 1'b0);
      check("post_rst_empty", Empty,    1'b1);

      // 2*DEPTH bytes while draining: pointer wrap keeps order
      busy_len = 1;
      for (int k = 0; k < 8; k++) begin
         push(1'b1, {8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k)}, 1'b0, 8'h00, 1'b1, 1'b0);
         repeat (8) @(posedge CLK);
      end
      wait_drain("wrap");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
